spectrum_frame_buffer: RTL

Sits between the FFT core and the graphics controller. Accepts one streamed FFT frame of N complex bins, converts each bin to an approximate magnitude, and buffers the frame in a shadow array. On a complete frame it commits the shadow array to the `freq_samples` output array in one cycle and pulses `fft_done`. The display therefore never sees a partially written frame.

---
 rtl/spectrum_pkg.sv | 19 +
 rtl/spectrum_frame_buffer_mag_approx.sv | 71 +++++++
 rtl/spectrum_frame_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// Shared types and sizing helpers for the spectrum frame buffer.
package spectrum_pkg;

  typedef enum logic [1:0] {
    S_FILL,
    S_DRAIN,
    S_COMMIT
  } state_e;

  function automatic int mag_w(input int width);
    return width + 2;
  endfunction

  // Largest magnitude representable on the display side.
  function automatic int sat_max(input int width);
    return (1 << (width + 2)) - 1;
  endfunction

endpackage

// File: rtl/spectrum_frame_buffer_mag_approx.sv
// Two-stage alpha-max-beta-min magnitude pipeline: stage 1 registers |re|,|im|,
// stage 2 registers max + min/2 saturated to the magnitude width.
module mag_approx
  import spectrum_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int IDX_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH+2:0] in_re,
  input  logic signed [WIDTH+2:0] in_im,
  input  logic [IDX_W-1:0]        in_idx,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_idx,
  output logic [WIDTH+1:0]        out_mag
);

  localparam int AW = WIDTH + 3;
  localparam int SW = WIDTH + 4;
  localparam int MW = mag_w(WIDTH);
  localparam logic [SW-1:0] SAT = SW'(sat_max(WIDTH));

  logic [1:0]       vld_pipe_d, vld_pipe_q;
  logic [AW-1:0]    abs_re_d, abs_re_q, abs_im_d, abs_im_q;
  logic [IDX_W-1:0] idx1_d, idx1_q, idx2_d, idx2_q;
  logic [MW-1:0]    mag_d, mag_q;
  logic [AW-1:0]    hi, lo;
  logic [SW-1:0]    sum;

  // Unsigned view of the negated value keeps -2^(AW-1) exact.
  function automatic logic [AW-1:0] abs_u(input logic [AW-1:0] v);
    return v[AW-1] ? (~v + AW'(1)) : v;
  endfunction

  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], in_valid};
    abs_re_d   = abs_u(in_re);
    abs_im_d   = abs_u(in_im);
    idx1_d     = in_idx;
    idx2_d     = idx1_q;
    hi         = (abs_re_q >= abs_im_q) ? abs_re_q : abs_im_q;
    lo         = (abs_re_q >= abs_im_q) ? abs_im_q : abs_re_q;
    sum        = {1'b0, hi} + {2'b00, lo[AW-1:1]};
    mag_d      = (sum > SAT) ? SAT[MW-1:0] : sum[MW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe_q <= '0;
      abs_re_q   <= '0;
      abs_im_q   <= '0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      mag_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      abs_re_q   <= abs_re_d;
      abs_im_q   <= abs_im_d;
      idx1_q     <= idx1_d;
      idx2_q     <= idx2_d;
      mag_q      <= mag_d;
    end
  end

  assign out_valid = vld_pipe_q[1];
  assign out_idx   = idx2_q;
  assign out_mag   = mag_q;

endmodule

// File: rtl/spectrum_frame_buffer.sv
// Buffers one FFT frame of magnitudes in a shadow array and commits it atomically.
// Optional PEAK_HOLD_EN: commit keeps max(new, decayed old) so bars fall gradually.
module spectrum_frame_buffer
  import spectrum_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int N           = 256,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                    clk_25MHz,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH+2:0] in_re,
  input  logic signed [WIDTH+2:0] in_im,
  input  logic                    in_last,
  output logic [WIDTH+1:0]        freq_samples [0:N-1],
  output logic                    fft_done,
  output logic                    frame_err
);

  localparam int MW = mag_w(WIDTH);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_e        state_d, state_q;
  logic [IW-1:0] idx_d, idx_q;
  logic          drain_d, drain_q;
  logic          in_ready_d, in_ready_q;
  logic          fft_done_d, fft_done_q;
  logic          frame_err_d, frame_err_q;
  logic [MW-1:0] shadow_d [0:N-1];
  logic [MW-1:0] shadow_q [0:N-1];
  logic [MW-1:0] freq_d   [0:N-1];
  logic [MW-1:0] freq_q   [0:N-1];
  logic          beat_ok;
  logic          pipe_vld;
  logic [IW-1:0] pipe_idx;
  logic [MW-1:0] pipe_mag;
`ifdef PEAK_HOLD_EN
  logic [MW-1:0] decayed;
`endif

  mag_approx #(
    .WIDTH (WIDTH),
    .IDX_W (IW)
  ) u_mag (
    .clk       (clk_25MHz),
    .rst       (rst),
    .in_valid  (beat_ok),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_idx    (idx_q),
    .out_valid (pipe_vld),
    .out_idx   (pipe_idx),
    .out_mag   (pipe_mag)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    drain_d     = drain_q;
    fft_done_d  = 1'b0;
    frame_err_d = 1'b0;
    beat_ok     = 1'b0;
    shadow_d    = shadow_q;
    freq_d      = freq_q;
`ifdef PEAK_HOLD_EN
    decayed     = '0;
`endif
    if (pipe_vld) shadow_d[pipe_idx] = pipe_mag;

    case (state_q)
      S_FILL: begin
        if (in_valid && in_ready_q) begin
          // in_last must coincide exactly with the final bin; anything else drops the frame
          if (in_last != (idx_q == LAST_IDX)) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else begin
            beat_ok = 1'b1;
            idx_d   = idx_q + IW'(1);
            if (in_last) begin
              state_d = S_DRAIN;
              drain_d = 1'b0;
            end
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_COMMIT;
      end
      S_COMMIT: begin
`ifdef PEAK_HOLD_EN
        for (int i = 0; i < N; i++) begin
          decayed   = freq_q[i] - (freq_q[i] >> DECAY_SHIFT);
          freq_d[i] = (shadow_q[i] > decayed) ? shadow_q[i] : decayed;
        end
`else
        for (int i = 0; i < N; i++) freq_d[i] = shadow_q[i];
`endif
        fft_done_d = 1'b1;
        idx_d      = '0;
        state_d    = S_FILL;
      end
      default: state_d = S_FILL;
    endcase

    // Stays low on the cycle after COMMIT so the frame costs N + 4 cycles.
    in_ready_d = (state_q == S_FILL) && (state_d == S_FILL);
  end

  always_ff @(posedge clk_25MHz) begin
    if (!rst) begin
      state_q     <= S_FILL;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      fft_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
        freq_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drain_q     <= drain_d;
      in_ready_q  <= in_ready_d;
      fft_done_q  <= fft_done_d;
      frame_err_q <= frame_err_d;
      shadow_q    <= shadow_d;
      freq_q      <= freq_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign fft_done     = fft_done_q;
  assign frame_err    = frame_err_q;
  assign freq_samples = freq_q;

endmodule
